wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//   Two-master / one-slave Wishbone B4 arbiter sharing the core's single memory bus between the
//   instruction fetch path (i_cache, master 0) and the load/store path (master 1). Grants a whole
//   bus cycle (CYC high to CYC low), including CTI bursts, to one master, muxes that master onto
//   the slave port, and routes ACK/ERR/RTY back to it only.
// PARAMETERS
//   RR_EN        1    1: round-robin between masters; 0: fixed priority, master 0 wins ties
//   TIMEOUT_CYC  255  watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN), 1..65535
// PORTS
//   clk          in   1   clock, all logic on rising edge
//   rst          in   1   synchronous reset, active-high
//   m0_CYC,m0_STB,m0_WE       in   1 each  master 0 (i_cache) cycle/strobe/write
//   m0_ADR,m0_DAT_O           in   32 each master 0 address / write data
//   m0_CTI_O                  in   3       master 0 cycle type
//   m0_ACK,m0_ERR,m0_RTY      out  1 each  master 0 terminations
//   m1_CYC,m1_STB,m1_WE       in   1 each  master 1 (load/store) cycle/strobe/write
//   m1_ADR,m1_DAT_O           in   32 each master 1 address / write data
//   m1_CTI_O                  in   3       master 1 cycle type
//   m1_ACK,m1_ERR,m1_RTY      out  1 each  master 1 terminations
//   m_DAT_I                   out  32      slave read data, broadcast to both masters
//   s_CYC,s_STB,s_WE          out  1 each  slave cycle/strobe/write
//   s_ADR,s_DAT_O             out  32 each slave address / write data
//   s_CTI_O                   out  3       slave cycle type
//   s_ACK,s_ERR,s_RTY         in   1 each  slave terminations
//   s_DAT_I                   in   32      slave read data
//   gnt                       out  2       one-hot current grant {m1,m0}; 2'b00 = none
// BEHAVIOUR
//   - FSM states IDLE, GNT0, GNT1 (+ ABORT with WB_ARB_TIMEOUT_EN). Reset -> IDLE, gnt=00,
//     rr_last=1 (so master 0 wins the first tie), all s_* and m*_ACK/ERR/RTY outputs 0.
//   - IDLE: sample m0_CYC/m1_CYC. One requester -> that GNTn next cycle. Both: RR_EN=0 -> GNT0;
//     RR_EN=1 -> the master not equal to rr_last. Grant latency is 1 cycle from CYC rise to s_CYC.
//   - GNTn: s_CYC,s_STB,s_WE,s_ADR,s_DAT_O,s_CTI_O = mn_* combinationally. mn_ACK/ERR/RTY =
//     s_ACK/ERR/RTY; the other master's ACK/ERR/RTY are forced 0. rr_last<=n on entry.
//   - In IDLE all s_* outputs are 0 (s_ADR/s_DAT_O = 0, s_CTI_O = 3'b000).
//   - Grant held while mn_CYC=1, regardless of the other master's CYC and of STB gaps or CTI.
//   - Release: mn_CYC=0 in GNTn. Other master's CYC=1 in the same cycle -> go directly to its GNT
//     (handoff, no IDLE bubble); else -> IDLE. A request arriving in the release cycle counts.
//   - Master-side outputs are never registered, so ACK reaches the master in the same cycle as s_ACK.
//   - A master dropping CYC mid-burst ends its grant immediately; s_CYC follows the same cycle.
//   - Slave terminations seen while gnt=00 are dropped. m_DAT_I = s_DAT_I always.
//   - rst asserted mid-cycle: next edge returns to IDLE with all outputs at reset values; no
//     termination is generated for the aborted transfer.
// CONFIGURATION
//   WB_ARB_TIMEOUT_EN defined: a 16-bit watchdog counts cycles with s_CYC&s_STB=1 and no s_ACK/
//     s_ERR/s_RTY. It clears on any termination or STB=0. On reaching TIMEOUT_CYC it pulses mn_ERR
//     for one cycle and enters ABORT. ABORT drives s_CYC=s_STB=0, ignores slave terminations, and
//     waits for mn_CYC=0, then follows the normal release rules.
//   WB_ARB_TIMEOUT_EN undefined: no counter, no ABORT state; a hung slave holds the grant forever.
// TESTING
//   - Reset: rst=1 for 2 cycles -> gnt=00, s_CYC=0, all m*_ACK/ERR/RTY=0.
//   - Single fetch: m0 CYC/STB, ADR=0x100, slave ACKs with DAT_I=0x00000013 after 2 cycles
//     -> s_CYC 1 cycle after m0_CYC, m0_ACK=1 and m_DAT_I=0x13, m1_ACK stays 0.
//   - Simultaneous request, RR_EN=1: m0 and m1 assert CYC in the same cycle, each does 1 transfer
//     -> gnt=01 then 10 by direct handoff (no IDLE cycle); repeat -> gnt=01 first again.
//   - Burst lock: m0 runs a 4-beat CTI=010/111 burst at 0x200 while m1 requests at beat 1
//     -> all 4 ACKs go to m0, and m1 is granted the cycle after m0_CYC falls.
//   - Fixed priority, RR_EN=0: both masters request continuously -> m0 granted every arbitration;
//     m1 is granted only in cycles where m0_CYC=0.
//   - Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): m1 write, slave never responds -> m1_ERR=1
//     exactly 8 cycles after s_STB rises, s_CYC=0 the next cycle, and a late s_ACK is ignored.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone B4 bus arbiter.
// Master 0 is the instruction fetch path and master 1 is the load/store path.
// A grant lasts for the whole bus cycle, from CYC high to CYC low, including CTI bursts.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort cycles that the slave never terminates.
module wb_bus_arbiter #(
  parameter bit RR_EN       = 1'b1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_CYC,
  input  logic        m0_STB,
  input  logic        m0_WE,
  input  logic [31:0] m0_ADR,
  input  logic [31:0] m0_DAT_O,
  input  logic [2:0]  m0_CTI_O,
  output logic        m0_ACK,
  output logic        m0_ERR,
  output logic        m0_RTY,
  input  logic        m1_CYC,
  input  logic        m1_STB,
  input  logic        m1_WE,
  input  logic [31:0] m1_ADR,
  input  logic [31:0] m1_DAT_O,
  input  logic [2:0]  m1_CTI_O,
  output logic        m1_ACK,
  output logic        m1_ERR,
  output logic        m1_RTY,
  output logic [31:0] m_DAT_I,
  output logic        s_CYC,
  output logic        s_STB,
  output logic        s_WE,
  output logic [31:0] s_ADR,
  output logic [31:0] s_DAT_O,
  output logic [2:0]  s_CTI_O,
  input  logic        s_ACK,
  input  logic        s_ERR,
  input  logic        s_RTY,
  input  logic [31:0] s_DAT_I,
  output logic [1:0]  gnt
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ABORT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
`endif

  state_t state, nxt;
  logic   rr_last;
  logic   pick1;

  // Master 1 wins when it is the only requester, or on a round-robin tie after master 0 was last served.
  assign pick1 = m1_CYC & (~m0_CYC | (RR_EN & ~rr_last));

  assign m_DAT_I = s_DAT_I;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] wd_cnt;
  logic        wd_act, s_term, tmo;

  assign s_term = s_ACK | s_ERR | s_RTY;
  assign wd_act = ((state == GNT0) & m0_CYC & m0_STB) | ((state == GNT1) & m1_CYC & m1_STB);
  assign tmo    = wd_act & ~s_term & (wd_cnt == TMO_LIM);

  // Watchdog: count strobed cycles that are waiting for a termination, and clear on any gap or response.
  always_ff @(posedge clk) begin
    if (rst || !wd_act || s_term) wd_cnt <= '0;
    else if (wd_cnt != 16'hFFFF)  wd_cnt <= wd_cnt + 16'd1;
  end
`endif

  // State register and round-robin history, which records the master most recently granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state <= nxt;
      if (nxt == GNT0 && state != GNT0)      rr_last <= 1'b0;
      else if (nxt == GNT1 && state != GNT1) rr_last <= 1'b1;
    end
  end

  // Next-state logic: hold the grant while the owner keeps CYC high, and hand off directly on release.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (m0_CYC | m1_CYC) nxt = pick1 ? GNT1 : GNT0;
      GNT0: begin
        if (!m0_CYC) nxt = m1_CYC ? GNT1 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo) nxt = ABORT;
`endif
      end
      GNT1: begin
        if (!m1_CYC) nxt = m0_CYC ? GNT0 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo) nxt = ABORT;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (rr_last && !m1_CYC)       nxt = m0_CYC ? GNT0 : IDLE;
        else if (!rr_last && !m0_CYC) nxt = m1_CYC ? GNT1 : IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // Output mux: connect the granted master to the slave, and return terminations to that master only.
  always_comb begin
    s_CYC = 1'b0; s_STB = 1'b0; s_WE = 1'b0;
    s_ADR = '0; s_DAT_O = '0; s_CTI_O = 3'b000;
    m0_ACK = 1'b0; m0_ERR = 1'b0; m0_RTY = 1'b0;
    m1_ACK = 1'b0; m1_ERR = 1'b0; m1_RTY = 1'b0;
    gnt = 2'b00;
    case (state)
      GNT0: begin
        s_CYC = m0_CYC; s_STB = m0_STB; s_WE = m0_WE;
        s_ADR = m0_ADR; s_DAT_O = m0_DAT_O; s_CTI_O = m0_CTI_O;
        m0_ACK = s_ACK; m0_ERR = s_ERR; m0_RTY = s_RTY;
        gnt = 2'b01;
      end
      GNT1: begin
        s_CYC = m1_CYC; s_STB = m1_STB; s_WE = m1_WE;
        s_ADR = m1_ADR; s_DAT_O = m1_DAT_O; s_CTI_O = m1_CTI_O;
        m1_ACK = s_ACK; m1_ERR = s_ERR; m1_RTY = s_RTY;
        gnt = 2'b10;
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: gnt = rr_last ? 2'b10 : 2'b01;
`endif
      default: ;
    endcase
`ifdef WB_ARB_TIMEOUT_EN
    if (tmo) begin
      if (state == GNT0) m0_ERR = 1'b1;
      else               m1_ERR = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: instance 0 uses round-robin and instance 1 uses fixed priority.
module tb_wb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        mcyc [2][2], mstb [2][2], mwe [2][2];
  logic [31:0] madr [2][2], mdat [2][2];
  logic [2:0]  mcti [2][2];
  logic        mack [2][2], merr [2][2], mrty [2][2];
  logic [31:0] mdi [2];
  logic        scyc [2], sstb [2], swe [2];
  logic [31:0] sadr [2], sdo [2];
  logic [2:0]  scti [2];
  logic        sack [2], serr [2], srty [2];
  logic [31:0] sdi [2];
  logic [1:0]  gnt [2];
  int checks = 0;
  int errors = 0;
  int   own [2];
  logic last [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_bus_arbiter #(.RR_EN(k == 0), .TIMEOUT_CYC(8)) u_dut (
      .clk(clk), .rst(rst),
      .m0_CYC(mcyc[k][0]), .m0_STB(mstb[k][0]), .m0_WE(mwe[k][0]), .m0_ADR(madr[k][0]),
      .m0_DAT_O(mdat[k][0]), .m0_CTI_O(mcti[k][0]),
      .m0_ACK(mack[k][0]), .m0_ERR(merr[k][0]), .m0_RTY(mrty[k][0]),
      .m1_CYC(mcyc[k][1]), .m1_STB(mstb[k][1]), .m1_WE(mwe[k][1]), .m1_ADR(madr[k][1]),
      .m1_DAT_O(mdat[k][1]), .m1_CTI_O(mcti[k][1]),
      .m1_ACK(mack[k][1]), .m1_ERR(merr[k][1]), .m1_RTY(mrty[k][1]),
      .m_DAT_I(mdi[k]),
      .s_CYC(scyc[k]), .s_STB(sstb[k]), .s_WE(swe[k]), .s_ADR(sadr[k]), .s_DAT_O(sdo[k]),
      .s_CTI_O(scti[k]), .s_ACK(sack[k]), .s_ERR(serr[k]), .s_RTY(srty[k]), .s_DAT_I(sdi[k]),
      .gnt(gnt[k]));
  end

  // Reference model: the bus owner (-1 means none) follows the arbitration rules. Instance 0 is round-robin.
  function automatic int next_owner(int k);
    int o;
    o = own[k];
    if (o < 0) begin
      if (mcyc[k][0] && mcyc[k][1]) return (k == 0 && !last[k]) ? 1 : 0;
      if (mcyc[k][0]) return 0;
      if (mcyc[k][1]) return 1;
      return -1;
    end
    if (mcyc[k][o]) return o;
    if (mcyc[k][1-o]) return 1 - o;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        own[k]  <= -1;
        last[k] <= 1'b1;
      end else begin
        own[k] <= next_owner(k);
        if (next_owner(k) >= 0 && next_owner(k) != own[k]) last[k] <= (next_owner(k) == 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        mcyc[k][j] = 0; mstb[k][j] = 0; mwe[k][j] = 0;
        madr[k][j] = '0; mdat[k][j] = '0; mcti[k][j] = '0;
      end
      sack[k] = 0; serr[k] = 0; srty[k] = 0; sdi[k] = '0;
    end
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1;
    sack[0] = 1; sack[1] = 1;
    tick(); tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt[k] !== 2'b00 || scyc[k] !== 1'b0 ||
          {mack[k][0], merr[k][0], mrty[k][0], mack[k][1], merr[k][1], mrty[k][1]} !== 6'b0) begin
        errors++;
        $display("FAIL reset[%0d] gnt=%b s_CYC=%b terms=%b%b%b%b%b%b want 00/0/000000", k, gnt[k], scyc[k],
                 mack[k][0], merr[k][0], mrty[k][0], mack[k][1], merr[k][1], mrty[k][1]);
      end
    end
    rst = 0;
    // Idle with non-zero master fields and slave terminations active: everything must stay quiet.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        mstb[k][j] = 1; mwe[k][j] = 1; madr[k][j] = 32'hFFFF_FFFF; mdat[k][j] = 32'hFFFF_FFFF; mcti[k][j] = 3'b111;
      end
      sack[k] = 1; serr[k] = 1; srty[k] = 1; sdi[k] = 32'hA5A5_A5A5;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({scyc[k], sstb[k], swe[k], sadr[k], sdo[k], scti[k]} !== 70'b0 ||
          {mack[k][0], merr[k][0], mrty[k][0], mack[k][1], merr[k][1], mrty[k][1]} !== 6'b0 ||
          mdi[k] !== 32'hA5A5_A5A5) begin
        errors++;
        $display("FAIL idle_quiet[%0d] s_ADR=%h s_CTI=%b s_WE=%b ack0=%b m_DAT_I=%h want all 0, m_DAT_I=a5a5a5a5",
                 k, sadr[k], scti[k], swe[k], mack[k][0], mdi[k]);
      end
    end
    tick();
    clear_in();
  endtask

  task automatic test_single_fetch();
    do_reset();
    mcyc[0][0] = 1; mstb[0][0] = 1; madr[0][0] = 32'h100;
    @(negedge clk);
    checks++;
    if (scyc[0] !== 1'b0) begin errors++; $display("FAIL fetch_latency s_CYC=%b want 0", scyc[0]); end
    tick();
    @(negedge clk);
    checks++;
    if (scyc[0] !== 1'b1 || sadr[0] !== 32'h100 || gnt[0] !== 2'b01 || mack[0][0] !== 1'b0) begin
      errors++; $display("FAIL fetch_grant s_CYC=%b s_ADR=%h gnt=%b ack=%b want 1/100/01/0", scyc[0], sadr[0], gnt[0], mack[0][0]);
    end
    tick(); tick();
    sack[0] = 1; sdi[0] = 32'h0000_0013;
    @(negedge clk);
    checks++;
    if (mack[0][0] !== 1'b1 || mdi[0] !== 32'h13 || mack[0][1] !== 1'b0) begin
      errors++; $display("FAIL fetch_ack m0_ACK=%b m_DAT_I=%h m1_ACK=%b want 1/00000013/0", mack[0][0], mdi[0], mack[0][1]);
    end
    tick();
    mcyc[0][0] = 0; mstb[0][0] = 0; sack[0] = 0;
    @(negedge clk);
    checks++;
    if (scyc[0] !== 1'b0) begin errors++; $display("FAIL fetch_drop s_CYC=%b want 0", scyc[0]); end
    tick();
    @(negedge clk);
    checks++;
    if (gnt[0] !== 2'b00) begin errors++; $display("FAIL fetch_release gnt=%b want 00", gnt[0]); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      mcyc[0][0] = 1; mstb[0][0] = 1; mcyc[0][1] = 1; mstb[0][1] = 1;
      tick();
      sack[0] = 1;
      @(negedge clk);
      checks++;
      if (gnt[0] !== 2'b01 || mack[0][0] !== 1'b1 || mack[0][1] !== 1'b0) begin
        errors++; $display("FAIL sim_first[%0d] gnt=%b ack0=%b ack1=%b want 01/1/0", r, gnt[0], mack[0][0], mack[0][1]);
      end
      tick();
      mcyc[0][0] = 0; mstb[0][0] = 0; sack[0] = 0;
      tick();
      sack[0] = 1;
      @(negedge clk);
      checks++;
      if (gnt[0] !== 2'b10 || mack[0][1] !== 1'b1 || mack[0][0] !== 1'b0 || scyc[0] !== 1'b1) begin
        errors++; $display("FAIL sim_handoff[%0d] gnt=%b ack1=%b ack0=%b s_CYC=%b want 10/1/0/1", r, gnt[0], mack[0][1], mack[0][0], scyc[0]);
      end
      tick();
      mcyc[0][1] = 0; mstb[0][1] = 0; sack[0] = 0;
      tick();
      @(negedge clk);
      checks++;
      if (gnt[0] !== 2'b00) begin errors++; $display("FAIL sim_idle[%0d] gnt=%b want 00", r, gnt[0]); end
    end
    tick();
  endtask

  task automatic test_burst_lock();
    do_reset();
    mcyc[0][0] = 1; mstb[0][0] = 1; madr[0][0] = 32'h200; mcti[0][0] = 3'b010;
    tick();
    for (int b = 0; b < 4; b++) begin
      madr[0][0] = 32'h200 + 32'(4 * b);
      mcti[0][0] = (b == 3) ? 3'b111 : 3'b010;
      if (b == 1) begin mcyc[0][1] = 1; mstb[0][1] = 1; end
      sack[0] = 1;
      @(negedge clk);
      checks++;
      if (gnt[0] !== 2'b01 || mack[0][0] !== 1'b1 || mack[0][1] !== 1'b0 ||
          sadr[0] !== 32'h200 + 32'(4 * b) || scti[0] !== mcti[0][0]) begin
        errors++; $display("FAIL burst_beat[%0d] gnt=%b ack0=%b ack1=%b s_ADR=%h s_CTI=%b", b, gnt[0], mack[0][0], mack[0][1], sadr[0], scti[0]);
      end
      tick();
    end
    mcyc[0][0] = 0; mstb[0][0] = 0; sack[0] = 0;
    tick();
    @(negedge clk);
    checks++;
    if (gnt[0] !== 2'b10) begin errors++; $display("FAIL burst_next gnt=%b want 10", gnt[0]); end
    tick();
    clear_in();
    tick();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] pg;
    logic pc0, pc1;
    int g1cnt, m1wins;
    do_reset();
    pg = 2'b00; pc0 = 0; pc1 = 0; g1cnt = 0; m1wins = 0;
    for (int i = 0; i < 200; i++) begin
      mcyc[1][0] = (i % 4) != 3; mstb[1][0] = mcyc[1][0];
      mcyc[1][1] = (g1cnt < 2);  mstb[1][1] = mcyc[1][1];
      #1 sack[1] = scyc[1] & sstb[1];
      @(negedge clk);
      if ((pg == 2'b00 || (pg == 2'b01 && !pc0) || (pg == 2'b10 && !pc1)) && pc0) begin
        checks++;
        if (gnt[1] !== 2'b01) begin errors++; $display("FAIL prio_m0_wins cyc %0d gnt=%b want 01", i, gnt[1]); end
      end
      if (gnt[1] == 2'b10 && pg != 2'b10) begin
        checks++; m1wins++;
        if (pc0 !== 1'b0) begin errors++; $display("FAIL prio_m1_grant cyc %0d prev m0_CYC=%b want 0", i, pc0); end
      end
      g1cnt = (gnt[1] == 2'b10) ? g1cnt + 1 : 0;
      pg = gnt[1]; pc0 = mcyc[1][0]; pc1 = mcyc[1][1];
      tick();
    end
    checks++;
    if (m1wins == 0) begin errors++; $display("FAIL prio_m1_served grants=%0d want >0", m1wins); end
    clear_in();
    tick();
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    mcyc[0][0] = 1; mstb[0][0] = 1;
    tick();
    rst = 1;
    tick();
    rst = 0; sack[0] = 1;
    @(negedge clk);
    checks++;
    if (gnt[0] !== 2'b00 || scyc[0] !== 1'b0 || mack[0][0] !== 1'b0) begin
      errors++; $display("FAIL midreset gnt=%b s_CYC=%b ack0=%b want 00/0/0", gnt[0], scyc[0], mack[0][0]);
    end
    tick();
    sack[0] = 0;
    @(negedge clk);
    checks++;
    if (gnt[0] !== 2'b01) begin errors++; $display("FAIL midreset_regrant gnt=%b want 01", gnt[0]); end
    clear_in();
    tick(); tick();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    mcyc[0][1] = 1; mstb[0][1] = 1; mwe[0][1] = 1; madr[0][1] = 32'h300;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (merr[0][1] !== 1'b0) begin errors++; $display("FAIL tmo_early cyc %0d m1_ERR=%b want 0", i, merr[0][1]); end
      tick();
    end
    @(negedge clk);
    checks++;
    if (merr[0][1] !== 1'b1 || scyc[0] !== 1'b1) begin
      errors++; $display("FAIL tmo_fire m1_ERR=%b s_CYC=%b want 1/1", merr[0][1], scyc[0]);
    end
    tick();
    sack[0] = 1;
    @(negedge clk);
    checks++;
    if (scyc[0] !== 1'b0 || mack[0][1] !== 1'b0 || merr[0][1] !== 1'b0) begin
      errors++; $display("FAIL tmo_abort s_CYC=%b m1_ACK=%b m1_ERR=%b want 0/0/0", scyc[0], mack[0][1], merr[0][1]);
    end
    tick();
    mcyc[0][1] = 0; mstb[0][1] = 0; sack[0] = 0;
    tick();
    @(negedge clk);
    checks++;
    if (gnt[0] !== 2'b00) begin errors++; $display("FAIL tmo_release gnt=%b want 00", gnt[0]); end
    tick();
  endtask
`endif

  task automatic test_random();
    int beats [2][2];
    int wait_c [2];
    int o, r;
    logic [1:0] e_gnt;
    logic [69:0] e_s;
    logic [5:0] e_t;
    do_reset();
    for (int k = 0; k < 2; k++) begin beats[k][0] = 0; beats[k][1] = 0; wait_c[k] = 0; end
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 2; j++) begin
          if (beats[k][j] == 0 && $urandom_range(0, 2) == 0) begin
            beats[k][j] = $urandom_range(1, 4);
            mwe[k][j] = 1'($urandom);
          end
          mcyc[k][j] = beats[k][j] > 0;
          mstb[k][j] = (beats[k][j] > 0) && ($urandom_range(0, 3) != 0);
          mcti[k][j] = (beats[k][j] > 1) ? 3'b010 : 3'b111;
          madr[k][j] = $urandom; mdat[k][j] = $urandom;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        sdi[k] = $urandom; sack[k] = 0; serr[k] = 0; srty[k] = 0;
        if (scyc[k] && sstb[k]) begin
          if (wait_c[k] >= 3 || $urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, 9);
            serr[k] = (r == 0); srty[k] = (r == 1); sack[k] = (r > 1);
            wait_c[k] = 0;
          end else wait_c[k]++;
        end else begin
          wait_c[k] = 0;
          sack[k] = (gnt[k] == 2'b00) && ($urandom_range(0, 3) == 0);
        end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        o = own[k];
        e_gnt = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
        e_s = '0; e_t = '0;
        if (o >= 0) begin
          e_s = {mcyc[k][o], mstb[k][o], mwe[k][o], madr[k][o], mdat[k][o], mcti[k][o]};
          if (o == 0) e_t = {sack[k], serr[k], srty[k], 3'b000};
          else        e_t = {3'b000, sack[k], serr[k], srty[k]};
        end
        checks++;
        if ({scyc[k], sstb[k], swe[k], sadr[k], sdo[k], scti[k]} !== e_s || gnt[k] !== e_gnt || mdi[k] !== sdi[k] ||
            {mack[k][0], merr[k][0], mrty[k][0], mack[k][1], merr[k][1], mrty[k][1]} !== e_t) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d gnt=%b want %b s_CYC=%b s_ADR=%h want %h terms=%b%b%b%b%b%b want %b",
                   k, i, gnt[k], e_gnt, scyc[k], sadr[k], e_s[37:6],
                   mack[k][0], merr[k][0], mrty[k][0], mack[k][1], merr[k][1], mrty[k][1], e_t);
        end
        if (o >= 0 && mstb[k][o] && (sack[k] || serr[k] || srty[k])) beats[k][o]--;
        if (rst) begin beats[k][0] = 0; beats[k][1] = 0; end
      end
      tick();
    end
    rst = 0;
    clear_in();
    tick();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_burst_lock();
    test_fixed_priority();
    test_reset_midcycle();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
